// File: rtl/display_scan_ctrl.sv
// Multiplexed 8-digit 7-segment scan controller for the 32-bit ALU result.
// A shadow register takes each new result. The value is copied into the display
// register only at a scan-frame boundary, so one frame never mixes two results.
// The digit index advances once per prescaler period. The output stage updates
// on the same tick and shows the digit slot that has just ended, so every output
// frame (an_o = FE .. 7F) is drawn from a single display value.
module display_scan_ctrl #(
    parameter int unsigned PRESCALE = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] dato_i,
    input  logic        c_i,
    input  logic        load_i,
    input  logic        blank_en_i,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [7:0]  an_o,
    output logic        pend_o,
    output logic        frame_o
);

    localparam int unsigned PrescW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PrescW-1:0] PrescMax = PrescW'(PRESCALE - 1);

    // Active-low hex glyphs, bit order gfedcba.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [PrescW-1:0] presc_q, presc_d;
    logic [2:0]        idx_q, idx_d;
    logic [32:0]       shadow_q, shadow_d;
    logic [32:0]       disp_q, disp_d;
    logic              pend_q, pend_d;
    logic [6:0]        seg_q, seg_d;
    logic [7:0]        an_q, an_d;
    logic              dp_q, dp_d;

    logic              tick;
    logic              frame;
    logic [31:0]       upper;
    logic              blank;

    assign tick  = (presc_q == PrescMax);
    assign frame = tick && (idx_q == 3'd7);

    // Prescaler and digit index: one slot per PRESCALE clocks, index wraps 7 -> 0.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (tick) begin
            presc_d = '0;
            idx_d   = idx_q + 3'd1;
        end else begin
            presc_d = presc_q + PrescW'(1);
        end
    end

    // Shadow capture and frame-boundary commit; a load coinciding with the
    // boundary bypasses the shadow so it is shown in the very next frame.
    always_comb begin
        shadow_d = shadow_q;
        pend_d   = pend_q;
        disp_d   = disp_q;
        if (load_i) begin
            shadow_d = {c_i, dato_i};
            pend_d   = 1'b1;
        end
        if (frame) begin
            if (load_i) begin
                disp_d = {c_i, dato_i};
                pend_d = 1'b0;
            end else if (pend_q) begin
                disp_d = shadow_q;
                pend_d = 1'b0;
            end
        end
    end

    // Digit decode for the current slot, including leading-zero blanking.
    always_comb begin
        // Bits from the current nibble upward; zero means this digit is a leading zero.
        upper = disp_q[31:0] >> {idx_q, 2'b00};
        blank = BLANK_LZ && blank_en_i && (idx_q != 3'd0) && (upper == 32'd0);
        seg_d = blank ? 7'h7F : hex7(upper[3:0]);
        an_d  = ~(8'b1 << idx_q);
        dp_d  = ~((idx_q == 3'd7) && disp_q[32]);
    end

    // Scan counters and value registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q  <= '0;
            idx_q    <= 3'd0;
            shadow_q <= '0;
            disp_q   <= '0;
            pend_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
        end
    end

    // Output stage: changes only on a tick, so anodes stay glitch-free between slots.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seg_q <= 7'h7F;
            an_q  <= 8'hFF;
            dp_q  <= 1'b1;
        end else if (tick) begin
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
        end
    end

    assign seg_o   = seg_q;
    assign an_o    = an_q;
    assign dp_o    = dp_q;
    assign pend_o  = pend_q;
    assign frame_o = frame;

endmodule
